// File: rtl/afe_seq_pkg.sv
// Shared state encodings, default widths and result field layout for the AFE injection scheduler.
package afe_seq_pkg;

  localparam int CNT_W_DEF  = 8;
  localparam int NINJ_W_DEF = 8;
  localparam int PER_W_DEF  = 16;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_PULSE = 2'd1;
  localparam state_t ST_GAP   = 2'd2;

  // Result word is {hit, tot}: tot in the low CNT_W bits, hit directly above it.
  localparam int RES_TOT_LSB = 0;
  localparam int RES_HIT_BIT = CNT_W_DEF;

endpackage

// File: rtl/afe_sync2.sv
// Two-flop synchronizer for the asynchronous comparator input; 2-cycle latency, resets to 0.
module afe_sync2 (
  input  logic clk,
  input  logic rst_b,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/afe_inj_scheduler.sv
// Injection burst sequencer: NINJ pulses of width w every p cycles, per-window {hit,tot} result over valid/ready.
// AFE_SEQ_TOT_EN keeps the TOT counter; without it only a sticky hit flag is reported and tot reads 0.
module afe_inj_scheduler
  import afe_seq_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int NINJ_W = NINJ_W_DEF,
  parameter int PER_W  = PER_W_DEF
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              start,
  input  logic              abort,
  input  logic [NINJ_W-1:0] ninj,
  input  logic [PER_W-1:0]  period,
  input  logic [7:0]        inj_width,
  input  logic              comp,
  output logic              inj,
  output logic              busy,
  output logic              done,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CNT_W:0]    res_data,
  output logic [NINJ_W-1:0] hit_cnt,
  output logic              ovf
);

  state_t            state;
  logic [PER_W-1:0]  per_cnt;
  logic [PER_W-1:0]  per_l;
  logic [7:0]        w_l;
  logic [NINJ_W-1:0] remaining;
  logic              comp_s;
  logic [CNT_W-1:0]  tot_upd;
  logic              hit_upd;
  logic              win_end;
  logic [7:0]        w_eff;
  logic [PER_W-1:0]  w_plus1;
  logic [PER_W-1:0]  p_eff;

  afe_sync2 u_comp_sync (
    .clk   (clk),
    .rst_b (rst_b),
    .d     (comp),
    .q     (comp_s)
  );

  // Guarantee a pulse of at least one cycle and at least one low cycle per period.
  assign w_eff   = (inj_width == 8'd0) ? 8'd1 : inj_width;
  assign w_plus1 = PER_W'(w_eff) + PER_W'(1);
  assign p_eff   = (period < w_plus1) ? w_plus1 : period;

  assign busy    = (state != ST_IDLE);
  assign win_end = (state == ST_GAP) && (per_cnt == per_l - PER_W'(1));

`ifdef AFE_SEQ_TOT_EN
  logic [CNT_W-1:0] tot;

  assign tot_upd = (comp_s && (tot != '1)) ? tot + CNT_W'(1) : tot;
  assign hit_upd = (tot_upd != '0);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)                           tot <= '0;
    else if ((state == ST_IDLE) || win_end) tot <= '0;
    else                                  tot <= tot_upd;
  end
`else
  logic hit_f;

  assign tot_upd = '0;
  assign hit_upd = hit_f | comp_s;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)                           hit_f <= 1'b0;
    else if ((state == ST_IDLE) || win_end) hit_f <= 1'b0;
    else                                  hit_f <= hit_upd;
  end
`endif

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= ST_IDLE;
      per_cnt   <= '0;
      per_l     <= '0;
      w_l       <= '0;
      remaining <= '0;
      inj       <= 1'b0;
      done      <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      hit_cnt   <= '0;
      ovf       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (res_valid && res_ready) res_valid <= 1'b0;

      if (abort) begin
        state   <= ST_IDLE;
        inj     <= 1'b0;
        per_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              if (ninj == '0) begin
                done <= 1'b1;
              end else begin
                state     <= ST_PULSE;
                inj       <= 1'b1;
                per_cnt   <= '0;
                per_l     <= p_eff;
                w_l       <= w_eff;
                remaining <= ninj;
                hit_cnt   <= '0;
                ovf       <= 1'b0;
              end
            end
          end
          ST_PULSE: begin
            per_cnt <= per_cnt + PER_W'(1);
            if (per_cnt == PER_W'(w_l) - PER_W'(1)) begin
              state <= ST_GAP;
              inj   <= 1'b0;
            end
          end
          ST_GAP: begin
            if (win_end) begin
              // A push in the same cycle as acceptance simply refills the slot.
              res_data  <= {hit_upd, tot_upd};
              res_valid <= 1'b1;
              if (res_valid && !res_ready) ovf <= 1'b1;
              if (hit_upd && (hit_cnt != '1)) hit_cnt <= hit_cnt + NINJ_W'(1);
              per_cnt   <= '0;
              remaining <= remaining - NINJ_W'(1);
              if (remaining == NINJ_W'(1)) begin
                state <= ST_IDLE;
                done  <= 1'b1;
              end else begin
                state <= ST_PULSE;
                inj   <= 1'b1;
              end
            end else begin
              per_cnt <= per_cnt + PER_W'(1);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_afe_inj_scheduler.sv
// Directed bench for afe_inj_scheduler; expected results follow AFE_SEQ_TOT_EN.
module tb_afe_inj_scheduler;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        comp = 1'b0;
  logic        res_ready = 1'b0;
  logic [7:0]  ninj = '0;
  logic [15:0] period = '0;
  logic [7:0]  inj_width = '0;
  logic        inj, busy, done, res_valid, ovf;
  logic [8:0]  res_data;
  logic [7:0]  hit_cnt;

  int vectors = 0;
  int miscompares = 0;
  int bad, nres, ndone, done_at;

`ifdef AFE_SEQ_TOT_EN
  localparam logic [8:0] EXP_T2  = 9'h106;
  localparam logic [8:0] EXP_T3A = 9'h101;
  localparam logic [8:0] EXP_T3B = 9'h102;
`else
  localparam logic [8:0] EXP_T2  = 9'h100;
  localparam logic [8:0] EXP_T3A = 9'h100;
  localparam logic [8:0] EXP_T3B = 9'h100;
`endif

  always #5 clk = ~clk;

  afe_inj_scheduler dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .start     (start),
    .abort     (abort),
    .ninj      (ninj),
    .period    (period),
    .inj_width (inj_width),
    .comp      (comp),
    .inj       (inj),
    .busy      (busy),
    .done      (done),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .hit_cnt   (hit_cnt),
    .ovf       (ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns in the first cycle of the burst (the expected first INJ-high cycle).
  task automatic launch(input logic [7:0] n, input logic [15:0] p, input logic [7:0] w);
    ninj = n;
    period = p;
    inj_width = w;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #2;
    check("rst_inj", inj, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_hit_cnt", hit_cnt, 0);
    check("rst_ovf", ovf, 0);
    tick();
    tick();
    rst_b = 1'b1;
    tick();

    // Three 4-cycle pulses, period 10, no comparator activity
    res_ready = 1'b1;
    launch(8'd3, 16'd10, 8'd4);
    check("t1_start_busy_inj", {busy, inj}, 2'b11);
    bad = 0; nres = 0; ndone = 0; done_at = -1;
    for (int k = 0; k <= 30; k++) begin
      if (inj !== ((k < 30) && ((k % 10) < 4))) bad++;
      if (res_valid) begin
        nres++;
        if (res_data !== 9'h000) bad++;
      end
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = k;
        if (busy !== 1'b0) bad++;
      end
      tick();
    end
    check("t1_inj_pattern_and_data", bad, 0);
    check("t1_result_count", nres, 3);
    check("t1_done_cycle", done_at, 30);
    check("t1_done_count", ndone, 1);
    check("t1_hit_cnt", hit_cnt, 0);

    // Single window, COMP high for 6 cycles starting 3 cycles after INJ rise
    launch(8'd1, 16'd20, 8'd4);
    for (int k = 0; k <= 20; k++) begin
      if (k == 19) check("t2_no_early_valid", res_valid, 0);
      if (k == 20) begin
        check("t2_res_valid", res_valid, 1);
        check("t2_res_data", res_data, EXP_T2);
        check("t2_hit_cnt", hit_cnt, 1);
        check("t2_done", done, 1);
        check("t2_busy_low", busy, 0);
      end
      comp = (k >= 3) && (k < 9);
      tick();
    end
    comp = 1'b0;

    // Consumer stalled: second result overwrites the first and flags overflow
    res_ready = 1'b0;
    launch(8'd2, 16'd10, 8'd3);
    for (int k = 0; k <= 20; k++) begin
      if (k == 10) begin
        check("t3_first_valid", res_valid, 1);
        check("t3_first_data", res_data, EXP_T3A);
        check("t3_no_ovf_yet", ovf, 0);
      end
      if (k == 20) begin
        check("t3_second_data", res_data, EXP_T3B);
        check("t3_ovf", ovf, 1);
        check("t3_done", done, 1);
        check("t3_hit_cnt", hit_cnt, 2);
      end
      comp = (k == 1) || (k == 11) || (k == 12);
      tick();
    end
    comp = 1'b0;
    check("t3_valid_held", res_valid, 1);
    res_ready = 1'b1;
    tick();
    check("t3_valid_cleared", res_valid, 0);
    check("t3_ovf_sticky", ovf, 1);

    // Period shorter than width: effective period is width+1
    launch(8'd1, 16'd2, 8'd5);
    check("t4_ovf_cleared", ovf, 0);
    bad = 0; done_at = -1;
    for (int k = 0; k <= 6; k++) begin
      if (inj !== (k < 5)) bad++;
      if (done && (done_at < 0)) done_at = k;
      tick();
    end
    check("t4_inj_pattern", bad, 0);
    check("t4_done_cycle", done_at, 6);

    // Zero width and zero period: one-cycle pulse, period 2
    launch(8'd1, 16'd0, 8'd0);
    bad = 0; done_at = -1;
    for (int k = 0; k <= 2; k++) begin
      if (inj !== (k < 1)) bad++;
      if (done && (done_at < 0)) done_at = k;
      tick();
    end
    check("t4_min_inj_pattern", bad, 0);
    check("t4_min_done_cycle", done_at, 2);

    // NINJ=0: DONE only
    launch(8'd0, 16'd10, 8'd4);
    check("t4_zero_done", done, 1);
    check("t4_zero_busy", busy, 0);
    check("t4_zero_inj", inj, 0);
    tick();
    check("t4_zero_done_pulse", done, 0);
    check("t4_zero_inj_after", inj, 0);

    // Abort during the second pulse of four
    launch(8'd4, 16'd8, 8'd4);
    nres = 0; ndone = 0;
    for (int k = 0; k <= 8; k++) begin
      if (res_valid) nres++;
      if (done) ndone++;
      tick();
    end
    check("t5_pre_abort_inj", inj, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_abort_inj", inj, 0);
    check("t5_abort_busy", busy, 0);
    for (int k = 0; k < 20; k++) begin
      if (res_valid) nres++;
      if (done) ndone++;
      tick();
    end
    check("t5_one_result", nres, 1);
    check("t5_no_done", ndone, 0);

    // Reset mid-burst with a pending result
    res_ready = 1'b0;
    launch(8'd2, 16'd6, 8'd2);
    for (int k = 0; k <= 6; k++) begin
      comp = (k < 2);
      tick();
    end
    comp = 1'b0;
    check("t6_pre_inj", inj, 1);
    check("t6_pre_valid", res_valid, 1);
    check("t6_pre_hit_cnt", hit_cnt, 1);
    rst_b = 1'b0;
    #1;
    check("t6_rst_inj", inj, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_valid", res_valid, 0);
    check("t6_rst_data", res_data, 0);
    check("t6_rst_hit_cnt", hit_cnt, 0);
    check("t6_rst_ovf", ovf, 0);
    tick();
    rst_b = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
